// File: rtl/softmax_argmax.sv
// Softmax / argmax classifier head.
// Scans a logit vector for its maximum, optionally drives an external exp engine,
// normalises the exponentials with a sequential restoring divider and streams
// the probabilities out under valid/ready flow control.
module softmax_argmax #(
  parameter int unsigned DATA_WIDTH    = 32,
  parameter int unsigned FRACTION_BITS = 20,
  parameter int unsigned MAX_NUM       = 16,
  parameter int unsigned ADR_WIDTH     = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start_i,
  input  logic [ADR_WIDTH:0]    cfg_len_i,
  input  logic                  cfg_argmax_only_i,
  output logic                  busy_o,
  output logic                  done_o,
  output logic [ADR_WIDTH-1:0]  rd_adr_o,
  input  logic [DATA_WIDTH-1:0] rd_data_i,
  output logic                  exp_start_o,
  output logic [DATA_WIDTH-1:0] exp_arg_o,
  input  logic                  exp_done_i,
  input  logic [DATA_WIDTH-1:0] exp_result_i,
  output logic                  out_valid_o,
  input  logic                  out_ready_i,
  output logic [ADR_WIDTH-1:0]  out_adr_o,
  output logic [DATA_WIDTH-1:0] out_data_o,
  output logic                  out_last_o,
  output logic [ADR_WIDTH-1:0]  argmax_idx_o,
  output logic [DATA_WIDTH-1:0] max_val_o
);

  localparam int unsigned LenW       = ADR_WIDTH + 1;
  localparam int unsigned RecipSteps = 2 * FRACTION_BITS + 1;
  localparam int unsigned CntW       = $clog2(RecipSteps);
  localparam int unsigned ProdW      = 2 * DATA_WIDTH;
  localparam logic [DATA_WIDTH-1:0] MaxPos = {1'b0, {(DATA_WIDTH - 1){1'b1}}};
  localparam logic [DATA_WIDTH-1:0] MinNeg = {1'b1, {(DATA_WIDTH - 1){1'b0}}};

  typedef enum logic [2:0] {
    StIdle, StMax, StExpReq, StExpWait, StRecip, StOut, StDone
  } state_e;

  state_e                 state_q, state_d;
  logic [ADR_WIDTH-1:0]   idx_q, idx_d;
  logic [LenW-1:0]        len_q, len_d;
  logic                   amo_q, amo_d;
  logic [DATA_WIDTH-1:0]  max_q, max_d;
  logic [ADR_WIDTH-1:0]   argmax_q, argmax_d;
  logic [DATA_WIDTH-1:0]  sum_q, sum_d;
  logic [DATA_WIDTH-1:0]  rem_q, rem_d;
  logic [DATA_WIDTH-1:0]  recip_q, recip_d;
  logic [CntW-1:0]        cnt_q, cnt_d;
  logic [DATA_WIDTH-1:0]  exp_buf_q [MAX_NUM];
  logic                   buf_we;

  logic                   last_elem;
  logic                   in_exp;
  logic [DATA_WIDTH:0]    rem_sh;
  logic signed [DATA_WIDTH:0] sum_ext;
  logic [DATA_WIDTH-1:0]  buf_rd;
  logic signed [ProdW-1:0] prod;

  assign last_elem = ({1'b0, idx_q} == (len_q - LenW'(1)));
  assign in_exp    = (state_q == StExpReq) || (state_q == StExpWait);
  assign buf_rd    = exp_buf_q[idx_q];

  // Next-state, datapath and divider step.
  always_comb begin
    state_d  = state_q;
    idx_d    = idx_q;
    len_d    = len_q;
    amo_d    = amo_q;
    max_d    = max_q;
    argmax_d = argmax_q;
    sum_d    = sum_q;
    rem_d    = rem_q;
    recip_d  = recip_q;
    cnt_d    = cnt_q;
    buf_we   = 1'b0;
    // Dividend is 2^(2*FRACTION_BITS): only its first (MSB) bit is set.
    rem_sh   = {rem_q, (cnt_q == '0)};
    sum_ext  = $signed({sum_q[DATA_WIDTH-1], sum_q}) +
               $signed({exp_result_i[DATA_WIDTH-1], exp_result_i});
    unique case (state_q)
      StIdle: begin
        if (start_i) begin
          state_d = StMax;
          idx_d   = '0;
          sum_d   = '0;
          amo_d   = cfg_argmax_only_i;
          len_d   = ((cfg_len_i == '0) || (cfg_len_i > LenW'(MAX_NUM))) ?
                    LenW'(MAX_NUM) : cfg_len_i;
        end
      end
      StMax: begin
        // Strict compare keeps the lowest index on ties.
        if ((idx_q == '0) || ($signed(rd_data_i) > $signed(max_q))) begin
          max_d    = rd_data_i;
          argmax_d = idx_q;
        end
        if (last_elem) begin
          idx_d   = '0;
          state_d = amo_q ? StDone : StExpReq;
        end else begin
          idx_d = idx_q + 1'b1;
        end
      end
      StExpReq: state_d = StExpWait;
      StExpWait: begin
        if (exp_done_i) begin
          buf_we = 1'b1;
          if (sum_ext[DATA_WIDTH] != sum_ext[DATA_WIDTH-1]) begin
            sum_d = sum_ext[DATA_WIDTH] ? MinNeg : MaxPos;
          end else begin
            sum_d = sum_ext[DATA_WIDTH-1:0];
          end
          if (last_elem) begin
            state_d = StRecip;
            cnt_d   = '0;
            rem_d   = '0;
            recip_d = '0;
          end else begin
            idx_d   = idx_q + 1'b1;
            state_d = StExpReq;
          end
        end
      end
      StRecip: begin
        if (rem_sh >= {1'b0, sum_q}) begin
          rem_d   = DATA_WIDTH'(rem_sh - {1'b0, sum_q});
          recip_d = {recip_q[DATA_WIDTH-2:0], 1'b1};
        end else begin
          rem_d   = rem_sh[DATA_WIDTH-1:0];
          recip_d = {recip_q[DATA_WIDTH-2:0], 1'b0};
        end
        if (cnt_q == CntW'(RecipSteps - 1)) begin
          state_d = StOut;
          idx_d   = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      StOut: begin
        if (out_ready_i) begin
          if (last_elem) begin
            state_d = StDone;
          end else begin
            idx_d = idx_q + 1'b1;
          end
        end
      end
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  // Control and result registers; reset aborts any run in progress.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= StIdle;
      idx_q    <= '0;
      len_q    <= '0;
      amo_q    <= 1'b0;
      max_q    <= '0;
      argmax_q <= '0;
      sum_q    <= '0;
      rem_q    <= '0;
      recip_q  <= '0;
      cnt_q    <= '0;
    end else begin
      state_q  <= state_d;
      idx_q    <= idx_d;
      len_q    <= len_d;
      amo_q    <= amo_d;
      max_q    <= max_d;
      argmax_q <= argmax_d;
      sum_q    <= sum_d;
      rem_q    <= rem_d;
      recip_q  <= recip_d;
      cnt_q    <= cnt_d;
    end
  end

  // Exponential buffer; contents are only read after being written in the same run.
  always_ff @(posedge clk) begin
    if (buf_we) begin
      exp_buf_q[idx_q] <= exp_result_i;
    end
  end

  // Output decode; everything is gated to zero outside the phase that drives it.
  always_comb begin
    prod         = $signed({{DATA_WIDTH{buf_rd[DATA_WIDTH-1]}}, buf_rd}) *
                   $signed({{DATA_WIDTH{1'b0}}, recip_q});
    busy_o       = (state_q != StIdle);
    done_o       = (state_q == StDone);
    exp_start_o  = (state_q == StExpReq);
    rd_adr_o     = ((state_q == StMax) || in_exp) ? idx_q : '0;
    exp_arg_o    = in_exp ? (rd_data_i - max_q) : '0;
    out_valid_o  = (state_q == StOut);
    out_adr_o    = out_valid_o ? idx_q : '0;
    out_last_o   = out_valid_o && last_elem;
    out_data_o   = out_valid_o ? DATA_WIDTH'(prod >>> FRACTION_BITS) : '0;
    argmax_idx_o = argmax_q;
    max_val_o    = max_q;
  end

endmodule

// File: tb/tb_softmax_argmax.sv
// Directed self-checking bench for softmax_argmax with a fixed-latency exp model.
module tb_softmax_argmax;

  localparam int DW = 32;
  localparam int AW = 4;
  localparam int K  = 3;
  localparam logic [DW-1:0] ONE  = 32'h0010_0000;
  localparam logic [DW-1:0] HALF = 32'h0008_0000;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          start = 1'b0;
  logic [AW:0]   cfg_len = '0;
  logic          cfg_argmax_only = 1'b0;
  logic          busy, done;
  logic [AW-1:0] rd_adr;
  logic [DW-1:0] rd_data;
  logic          exp_start;
  logic [DW-1:0] exp_arg;
  logic          exp_done = 1'b0;
  logic [DW-1:0] exp_result = '0;
  logic          out_valid;
  logic          out_ready = 1'b1;
  logic [AW-1:0] out_adr;
  logic [DW-1:0] out_data;
  logic          out_last;
  logic [AW-1:0] argmax_idx;
  logic [DW-1:0] max_val;

  logic [DW-1:0] mem [16];
  assign rd_data = mem[rd_adr];

  always #5 clk = ~clk;

  softmax_argmax dut (
    .clk              (clk),
    .rst_n            (rst_n),
    .start_i          (start),
    .cfg_len_i        (cfg_len),
    .cfg_argmax_only_i(cfg_argmax_only),
    .busy_o           (busy),
    .done_o           (done),
    .rd_adr_o         (rd_adr),
    .rd_data_i        (rd_data),
    .exp_start_o      (exp_start),
    .exp_arg_o        (exp_arg),
    .exp_done_i       (exp_done),
    .exp_result_i     (exp_result),
    .out_valid_o      (out_valid),
    .out_ready_i      (out_ready),
    .out_adr_o        (out_adr),
    .out_data_o       (out_data),
    .out_last_o       (out_last),
    .argmax_idx_o     (argmax_idx),
    .max_val_o        (max_val)
  );

  // Exp engine model: result K cycles after exp_start; e^0 = 1.0, anything else 0.5.
  int n_exp_start = 0;
  always @(negedge clk) if (exp_start) n_exp_start++;

  initial begin
    forever begin
      @(negedge clk);
      if (exp_start) begin
        repeat (K) @(posedge clk);
        #1;
        exp_result = (exp_arg == '0) ? ONE : HALF;
        exp_done   = 1'b1;
        @(posedge clk);
        #1;
        exp_done = 1'b0;
      end
    end
  end

  int n_chk = 0;
  int n_bad = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Per-run observations gathered by collect().
  logic [DW-1:0] got_data [16];
  logic [AW-1:0] got_adr  [16];
  logic          got_last [16];
  int n_hs, n_done, done_cyc, stall_bad, max_rd, last_expd, first_v;

  task automatic fill(input logic [DW-1:0] v);
    for (int i = 0; i < 16; i++) mem[i] = v;
  endtask

  task automatic start_run(input logic [AW:0] len, input logic amo);
    @(posedge clk); #1;
    cfg_len = len;
    cfg_argmax_only = amo;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    // Scramble config after sampling; it must have no effect.
    cfg_len = ~len;
    cfg_argmax_only = ~amo;
  endtask

  task automatic collect(input bit bp, input bit poke);
    logic          held_v;
    logic [DW-1:0] h_data;
    logic [AW-1:0] h_adr;
    logic          h_last;
    n_hs = 0; n_done = 0; done_cyc = -1; stall_bad = 0; max_rd = 0;
    last_expd = -1; first_v = -1; held_v = 1'b0;
    h_data = '0; h_adr = '0; h_last = 1'b0;
    for (int c = 0; c < 3000; c++) begin
      @(posedge clk); #1;
      out_ready = bp ? ((c % 3) == 0) : 1'b1;
      start = poke && (first_v >= 0) && (c == first_v + 1);
      if (start) begin
        cfg_len = 5'd1;
        cfg_argmax_only = 1'b1;
      end
      @(negedge clk);
      if (busy && (int'(rd_adr) > max_rd)) max_rd = int'(rd_adr);
      if (exp_done) last_expd = c;
      if (out_valid && (first_v < 0)) first_v = c;
      if (held_v && (!out_valid || out_data != h_data || out_adr != h_adr ||
                     out_last != h_last)) stall_bad++;
      held_v = out_valid && !out_ready;
      h_data = out_data; h_adr = out_adr; h_last = out_last;
      if (out_valid && out_ready) begin
        if (n_hs < 16) begin
          got_data[n_hs] = out_data;
          got_adr[n_hs]  = out_adr;
          got_last[n_hs] = out_last;
        end
        n_hs++;
      end
      if (done) begin
        n_done++;
        if (done_cyc < 0) done_cyc = c;
        break;
      end
    end
    start = 1'b0;
    out_ready = 1'b1;
  endtask

  int cnt;
  int extra;

  initial begin
    fill('0);
    // Reset state
    repeat (2) @(posedge clk);
    #1;
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_exp_start", exp_start, 0);
    check("rst_out_valid", out_valid, 0);
    check("rst_out_last", out_last, 0);
    check("rst_rd_adr", rd_adr, 0);
    check("rst_argmax", argmax_idx, 0);
    check("rst_max_val", max_val, 0);
    check("rst_out_data", out_data, 0);
    check("rst_exp_arg", exp_arg, 0);
    @(posedge clk); #1;
    rst_n = 1'b1;

    // Argmax-only with tie at indices 2 and 3
    mem[0] = 32'(3) << 20;  mem[1] = -(32'(1) << 20); mem[2] = 32'(7) << 20;
    mem[3] = 32'(7) << 20;  mem[4] = 32'(2) << 20;    mem[5] = '0;
    mem[6] = -(32'(5) << 20); mem[7] = 32'(1) << 20;  mem[8] = 32'(6) << 20;
    mem[9] = 32'(4) << 20;
    cnt = n_exp_start;
    start_run(5'd10, 1'b1);
    check("am_busy", busy, 1);
    collect(1'b0, 1'b0);
    check("am_idx", argmax_idx, 2);
    check("am_max", max_val, 32'h0070_0000);
    check("am_done_cyc", done_cyc, 9);
    check("am_no_exp", n_exp_start - cnt, 0);
    check("am_no_out", n_hs, 0);
    @(negedge clk);
    check("am_idx_held", argmax_idx, 2);

    // Uniform softmax, L=4
    fill('0);
    start_run(5'd4, 1'b0);
    collect(1'b0, 1'b0);
    check("uni_hs", n_hs, 4);
    check("uni_recip_cyc", first_v - last_expd, 42);
    check("uni_done", n_done, 1);
    for (int i = 0; i < 4; i++) begin
      check($sformatf("uni_data%0d", i), got_data[i], 32'h0004_0000);
      check($sformatf("uni_adr%0d", i), got_adr[i], i);
      check($sformatf("uni_last%0d", i), got_last[i], (i == 3));
    end

    // Backpressure: exps {1, .5, 1, .5}, sum 3.0, recip 0x55555
    mem[0] = '0; mem[1] = -ONE; mem[2] = '0; mem[3] = -ONE;
    start_run(5'd4, 1'b0);
    collect(1'b1, 1'b0);
    check("bp_hs", n_hs, 4);
    check("bp_stall", stall_bad, 0);
    check("bp_argmax", argmax_idx, 0);
    for (int i = 0; i < 4; i++) begin
      check($sformatf("bp_data%0d", i), got_data[i], (i % 2 == 0) ? 32'h0005_5555 : 32'h0002_AAAA);
      check($sformatf("bp_adr%0d", i), got_adr[i], i);
    end

    // Length 1
    fill('0);
    start_run(5'd1, 1'b0);
    collect(1'b0, 1'b0);
    check("len1_hs", n_hs, 1);
    check("len1_data", got_data[0], ONE);
    check("len1_last", got_last[0], 1);

    // Length 0 clamps to 16
    start_run(5'd0, 1'b0);
    collect(1'b0, 1'b0);
    check("len0_hs", n_hs, 16);
    check("len0_max_rd", max_rd, 15);
    check("len0_data15", got_data[15], 32'h0001_0000);
    check("len0_adr15", got_adr[15], 15);
    check("len0_last15", got_last[15], 1);
    check("len0_last14", got_last[14], 0);

    // Reset during EXP_WAIT of element 2
    mem[0] = ONE; mem[1] = 32'h0030_0000; mem[2] = 32'h0020_0000; mem[3] = HALF;
    start_run(5'd4, 1'b0);
    cnt = 0;
    for (int c = 0; c < 500 && cnt < 3; c++) begin
      @(negedge clk);
      if (exp_start) cnt++;
    end
    check("mid_third_req", cnt, 3);
    @(posedge clk); #1;
    check("mid_pre_rd_adr", rd_adr, 2);
    rst_n = 1'b0;
    #1;
    check("mid_busy", busy, 0);
    check("mid_exp_start", exp_start, 0);
    check("mid_rd_adr", rd_adr, 0);
    check("mid_exp_arg", exp_arg, 0);
    check("mid_max_val", max_val, 0);
    check("mid_argmax", argmax_idx, 0);
    check("mid_out_valid", out_valid, 0);
    check("mid_done", done, 0);
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    repeat (10) @(posedge clk);
    #1;
    check("mid_idle_after", busy, 0);
    fill('0);
    start_run(5'd4, 1'b0);
    collect(1'b0, 1'b0);
    check("mid_rerun_hs", n_hs, 4);
    check("mid_rerun_data0", got_data[0], 32'h0004_0000);
    check("mid_rerun_data3", got_data[3], 32'h0004_0000);
    check("mid_rerun_last3", got_last[3], 1);

    // Start asserted during OUT must be ignored
    start_run(5'd4, 1'b0);
    collect(1'b0, 1'b1);
    check("sb_hs", n_hs, 4);
    check("sb_data3", got_data[3], 32'h0004_0000);
    check("sb_done", n_done, 1);
    extra = 0;
    for (int c = 0; c < 60; c++) begin
      @(negedge clk);
      if (busy || done) extra++;
    end
    check("sb_no_restart", extra, 0);

    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end

endmodule

// File: doc/softmax_argmax.md
# softmax_argmax

Parametrised softmax/argmax classifier head for the CNN back end. It reads a vector of up to MAX_NUM signed fixed-point logits over an asynchronous-read address port and finds the maximum and its index. In full mode it drives an external exponential engine, normalises with an internal sequential reciprocal divider, and streams probabilities out under valid/ready backpressure. In argmax-only mode it skips the exponential and normalisation phases.

## Interface
- DATA_WIDTH, 32, logit/probability word width (signed two's complement, Q format)
- FRACTION_BITS, 20, fractional bits of every data word
- MAX_NUM, 16, maximum vector length; internal exp buffer depth
- ADR_WIDTH, 4, address width; 2^ADR_WIDTH >= MAX_NUM
- clk  in  1  clock
- rst_n  in  1  reset; asynchronous, active-low
- start  in  1  request; accepted only in IDLE
- cfg_len  in  ADR_WIDTH+1  vector length, sampled at start
- cfg_argmax_only  in  1  1 = argmax only, sampled at start
- busy  out  1  high in every state except IDLE
- done  out  1  one-cycle pulse at end of run
- rd_adr  out  ADR_WIDTH  logit read address
- rd_data  in  DATA_WIDTH  logit at rd_adr, valid in the same cycle
- exp_start  out  1  one-cycle request to the exp engine
- exp_arg  out  DATA_WIDTH  rd_data - max_val (always <= 0)
- exp_done  in  1  exp result valid pulse
- exp_result  in  DATA_WIDTH  e^exp_arg, Q(FRACTION_BITS)
- out_valid  out  1  probability word valid
- out_ready  in  1  sink accepts word
- out_adr  out  ADR_WIDTH  index of current probability
- out_data  out  DATA_WIDTH  probability, Q(FRACTION_BITS)
- out_last  out  1  marks the final word (index len-1)
- argmax_idx  out  ADR_WIDTH  index of maximum logit, held after run
- max_val  out  DATA_WIDTH  maximum logit, held after run

## Operation
- Length L = cfg_len when it is between 1 and MAX_NUM. Any other value (including 0) is clamped to MAX_NUM.
- States and transitions:
  - IDLE: on start, go to MAX.
  - MAX: one element per cycle, i = 0..L-1. Element 0 loads max_val and argmax_idx unconditionally. Later elements update only if strictly greater, so ties keep the lowest index. After i = L-1, go to DONE if argmax-only, else EXP_REQ.
  - EXP_REQ: exp_start = 1, rd_adr = i. Go to EXP_WAIT.
  - EXP_WAIT: rd_adr is held at i. On exp_done:
    - write exp_result into buffer[i];
    - add exp_result to sum, saturating at the maximum positive value;
    - go to EXP_REQ for the next i, or to RECIP after i = L-1.
  - RECIP: restoring division, one quotient bit per cycle. recip = floor(2^(2*FRACTION_BITS) / sum). Go to OUT.
  - OUT: out_data = (buffer[i] * recip) >>> FRACTION_BITS, truncated to DATA_WIDTH, with out_adr = i. Advance i on out_valid && out_ready. Go to DONE after handshake of i = L-1.
  - DONE: done = 1 for one cycle, then go to IDLE.
- sum is cleared on start. Because the maximum element contributes e^0 = 1.0, sum >= 2^FRACTION_BITS and recip <= 2^FRACTION_BITS.
- Full-precision product width is 2*DATA_WIDTH before the shift.
- start is ignored while busy. cfg_* changes after start have no effect.
- Asynchronous reset mid-run aborts immediately; all outputs return to reset values. The exp engine is not waited on, and a late exp_done arriving in IDLE is ignored.

## Timing
- Reset values:
  - busy, done, exp_start, out_valid, out_last = 0;
  - rd_adr, out_adr, argmax_idx = 0;
  - max_val, exp_arg, out_data = 0.
- start sampled in IDLE at edge n: MAX runs at edges n+1..n+L, and busy is high from n+1.
- Argmax-only: done is high in cycle n+L+1. argmax_idx and max_val are valid from that cycle until the next start.
- Full mode, exp engine latency k cycles from exp_start to exp_done: each element takes k+1 cycles. RECIP takes exactly 2*FRACTION_BITS+1 cycles. OUT takes at least L cycles. done follows the last handshake by one cycle.
- Backpressure: while out_valid && !out_ready, out_data, out_adr and out_last must hold stable. out_valid never drops before its handshake.
- exp_arg is combinational from rd_data and stays stable throughout EXP_REQ/EXP_WAIT.

## Test plan
- Argmax-only tie-break:
  - Stimulus: L=10, logits {3,-1,7,7,2,0,-5,1,6,4} in Q20.
  - Required: argmax_idx=2, max_val=0x00700000, done in cycle n+11, exp_start never asserted.
- Uniform softmax:
  - Stimulus: L=4, all logits 0, bench exp model with k=3.
  - Required: four words 0x00040000 (0.25), out_adr 0..3, out_last only on the 4th word, RECIP lasting 41 cycles.
- Backpressure:
  - Stimulus: L=4, out_ready toggling 1,0,0,1,...
  - Required: out_data/out_adr frozen during stalls, exactly 4 handshakes, no duplicates or drops.
- Length boundaries:
  - Stimulus: cfg_len=1.
  - Required: single word 0x00100000 (1.0) with out_last=1.
  - Stimulus: cfg_len=0.
  - Required: run processes 16 elements (rd_adr reaches 15).
- Reset mid-run:
  - Stimulus: rst_n low during EXP_WAIT of element 2.
  - Required: all outputs at reset values in the same cycle. A subsequent start completes a correct full run.
- Start while busy:
  - Stimulus: assert start during OUT.
  - Required: no restart; current stream completes and exactly one done pulse occurs.
